// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: coprocessor-0 operation codes, register numbers, bit positions and FSM states
package cp0_unit_pkg;
  localparam logic [1:0] EXE_CP_NONE  = 2'd0;
  localparam logic [1:0] EXE_CP_STORE = 2'd1;
  localparam logic [1:0] EXE_CP0_ERET = 2'd2;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_EHBR   = 5'd15;
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_IP2  = 10;
  localparam logic [31:0] EHBR_RESET = 32'h0000_0008;
  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_ISR, S_EXIT} cp0_state_t;
endpackage

// File: rtl/cp0_unit_irq_sync.sv
// irq_sync: two-flop synchronizer for the external interrupt plus a rising-edge detector
module irq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign rise = s2 & ~s3;
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 register file with interrupt entry/return FSM driving pipeline redirects
module cp0_unit
  import cp0_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  input  logic        irq,
  output logic        jump_en,
  output logic [31:0] jump_addr
);
  cp0_state_t  state;
  logic        rise, ie, exl, pending;
  logic [31:0] epc, ehbr;
  logic        open_st, take, eret, mtc0;

  irq_sync u_sync (.clk(clk), .rst_n(rst_n), .irq(irq), .rise(rise));

  // entry outranks any same-cycle oper; ret_addr capture makes that instruction replay
  assign open_st = (state == S_IDLE) || (state == S_ISR);
  assign take    = en && (state == S_IDLE) && pending && ie && !exl;
  assign eret    = en && open_st && !take && (oper == EXE_CP0_ERET);
  assign mtc0    = en && open_st && !take && (oper == EXE_CP_STORE);

  always_comb begin
    data_r = (addr_r == CP0_STATUS) ? {30'd0, exl, ie} :
             (addr_r == CP0_CAUSE)  ? {21'd0, pending, 10'd0} :
             (addr_r == CP0_EPC)    ? epc :
             (addr_r == CP0_EHBR)   ? ehbr : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ie        <= 1'b0;
      exl       <= 1'b0;
      pending   <= 1'b0;
      epc       <= 32'd0;
      ehbr      <= EHBR_RESET;
      jump_en   <= 1'b0;
      jump_addr <= 32'd0;
    end else begin
      pending <= rise | (pending & ~take);
      jump_en <= take | eret;
      if (take) begin
        state     <= S_ENTER;
        epc       <= ret_addr;
        exl       <= 1'b1;
        jump_addr <= ehbr;
      end else if (eret) begin
        state     <= S_EXIT;
        exl       <= 1'b0;
        jump_addr <= epc;
      end else begin
        state <= (state == S_ENTER) ? S_ISR : (state == S_EXIT) ? S_IDLE : state;
        if (mtc0 && addr_w == CP0_STATUS) {exl, ie} <= {data_w[STATUS_EXL], data_w[STATUS_IE]};
        if (mtc0 && addr_w == CP0_EPC) epc <= data_w;
        if (mtc0 && addr_w == CP0_EHBR) ehbr <= data_w;
      end
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: table-driven vectors with an expected-result queue, plus reset corner sequences
module tb_cp0_unit;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, irq = 1'b0, jump_en;
  logic [1:0]  oper = 2'd0;
  logic [4:0]  addr_r = 5'd0, addr_w = 5'd0;
  logic [31:0] data_w = 32'd0, ret_addr = 32'd0, data_r, jump_addr;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic en; logic [1:0] op; logic [4:0] ar, aw; logic [31:0] dw, ra; logic irq;
    logic [31:0] dr; logic je; logic [31:0] ja;
  } vec_t;
  typedef struct { logic [31:0] dr; logic je; logic [31:0] ja; int idx; } exp_t;
  vec_t tbl[36];
  exp_t sb[$];

  cp0_unit dut (.clk(clk), .rst_n(rst_n), .en(en), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ret_addr(ret_addr), .irq(irq), .jump_en(jump_en),
    .jump_addr(jump_addr));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic [1:0] op, logic [4:0] ar, logic [4:0] aw,
      logic [31:0] dw, logic [31:0] ra, logic iq, logic [31:0] dr, logic je, logic [31:0] ja);
    vec_t v;
    v.en = e; v.op = op; v.ar = ar; v.aw = aw; v.dw = dw; v.ra = ra; v.irq = iq;
    v.dr = dr; v.je = je; v.ja = ja;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  // called at a negedge: drive, queue the expectation, then compare after the next posedge
  task automatic apply(vec_t v, int idx);
    exp_t e;
    en = v.en; oper = v.op; addr_r = v.ar; addr_w = v.aw; data_w = v.dw;
    ret_addr = v.ra; irq = v.irq;
    sb.push_back('{v.dr, v.je, v.ja, idx});
    @(negedge clk);
    e = sb.pop_front();
    chk("data_r", e.idx, data_r, e.dr);
    chk("jump_en", e.idx, {31'd0, jump_en}, {31'd0, e.je});
    chk("jump_addr", e.idx, jump_addr, e.ja);
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 12, 12, 32'h1,        0,     0, 32'h1,   0, 32'h0);
    tbl[1]  = mk(1, 1, 13, 13, 32'hFFFFFFFF, 0,     0, 32'h0,   0, 32'h0);
    tbl[2]  = mk(1, 0, 15, 0,  0,            0,     0, 32'h8,   0, 32'h0);
    tbl[3]  = mk(1, 1, 7,  7,  32'h5,        0,     0, 32'h0,   0, 32'h0);
    tbl[4]  = mk(1, 0, 13, 0,  0,            32'h40, 1, 32'h0,  0, 32'h0);
    tbl[5]  = mk(1, 0, 13, 0,  0,            32'h40, 1, 32'h0,  0, 32'h0);
    tbl[6]  = mk(1, 0, 13, 0,  0,            32'h40, 1, 32'h400, 0, 32'h0);
    tbl[7]  = mk(1, 0, 14, 0,  0,            32'h40, 1, 32'h40, 1, 32'h8);
    tbl[8]  = mk(1, 0, 12, 0,  0,            32'h40, 1, 32'h3,  0, 32'h8);
    tbl[9]  = mk(1, 0, 13, 0,  0,            32'h40, 0, 32'h0,  0, 32'h8);
    tbl[10] = mk(1, 0, 13, 0,  0,            32'h40, 0, 32'h0,  0, 32'h8);
    tbl[11] = mk(1, 0, 13, 0,  0,            32'h40, 1, 32'h0,  0, 32'h8);
    tbl[12] = mk(1, 0, 13, 0,  0,            32'h40, 1, 32'h0,  0, 32'h8);
    tbl[13] = mk(1, 0, 13, 0,  0,            32'h40, 1, 32'h400, 0, 32'h8);
    tbl[14] = mk(0, 2, 12, 0,  0,            32'h40, 1, 32'h3,  0, 32'h8);
    tbl[15] = mk(1, 2, 12, 0,  0,            32'h40, 1, 32'h1,  1, 32'h40);
    tbl[16] = mk(1, 0, 13, 0,  0,            32'h80, 1, 32'h400, 0, 32'h40);
    tbl[17] = mk(1, 0, 14, 0,  0,            32'h80, 1, 32'h80, 1, 32'h8);
    tbl[18] = mk(1, 0, 12, 0,  0,            32'h80, 1, 32'h3,  0, 32'h8);
    tbl[19] = mk(1, 2, 14, 0,  0,            32'h80, 1, 32'h80, 1, 32'h80);
    tbl[20] = mk(1, 0, 12, 0,  0,            32'h80, 1, 32'h1,  0, 32'h80);
    tbl[21] = mk(1, 0, 12, 0,  0,            32'h80, 0, 32'h1,  0, 32'h80);
    tbl[22] = mk(1, 0, 12, 0,  0,            32'h80, 0, 32'h1,  0, 32'h80);
    tbl[23] = mk(1, 0, 12, 0,  0,            32'h80, 1, 32'h1,  0, 32'h80);
    tbl[24] = mk(1, 0, 12, 0,  0,            32'h80, 1, 32'h1,  0, 32'h80);
    tbl[25] = mk(0, 0, 13, 0,  0,            32'h80, 1, 32'h400, 0, 32'h80);
    tbl[26] = mk(0, 0, 13, 0,  0,            32'h80, 1, 32'h400, 0, 32'h80);
    tbl[27] = mk(1, 1, 15, 15, 32'h100,      32'h44, 1, 32'h8,  1, 32'h8);
    tbl[28] = mk(1, 0, 14, 0,  0,            32'h44, 1, 32'h44, 0, 32'h8);
    tbl[29] = mk(1, 1, 14, 14, 32'h200,      32'h44, 1, 32'h200, 0, 32'h8);
    tbl[30] = mk(1, 2, 12, 0,  0,            32'h44, 1, 32'h1,  1, 32'h200);
    tbl[31] = mk(1, 0, 12, 0,  0,            32'h44, 1, 32'h1,  0, 32'h200);
    tbl[32] = mk(1, 2, 12, 0,  0,            32'h44, 1, 32'h1,  1, 32'h200);
    tbl[33] = mk(1, 0, 12, 0,  0,            32'h44, 1, 32'h1,  0, 32'h200);
    tbl[34] = mk(1, 3, 12, 12, 32'h0,        32'h44, 1, 32'h1,  0, 32'h200);
    tbl[35] = mk(1, 1, 15, 15, 32'h100,      32'h44, 1, 32'h100, 0, 32'h200);

    addr_r = 5'd15;
    repeat (2) @(negedge clk);
    chk("rst_ehbr", 0, data_r, 32'h8);
    chk("rst_je", 0, {31'd0, jump_en}, 32'd0);
    chk("rst_ja", 0, jump_addr, 32'd0);
    addr_r = 5'd12;
    #1 chk("rst_status", 0, data_r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) apply(tbl[i], i);

    // new interrupt edge into handler base 0x100, then reset lands while in ENTER
    apply(mk(1, 0, 12, 0, 0, 32'h60, 0, 32'h1, 0, 32'h200), 100);
    apply(mk(1, 0, 12, 0, 0, 32'h60, 0, 32'h1, 0, 32'h200), 101);
    apply(mk(1, 0, 12, 0, 0, 32'h60, 1, 32'h1, 0, 32'h200), 102);
    apply(mk(1, 0, 12, 0, 0, 32'h60, 1, 32'h1, 0, 32'h200), 103);
    apply(mk(1, 0, 13, 0, 0, 32'h60, 1, 32'h400, 0, 32'h200), 104);
    apply(mk(1, 0, 14, 0, 0, 32'h60, 1, 32'h60, 1, 32'h100), 105);
    #2 rst_n = 1'b0;
    irq = 1'b0;
    #1;
    chk("arst_je", 106, {31'd0, jump_en}, 32'd0);
    chk("arst_ja", 106, jump_addr, 32'd0);
    chk("arst_epc", 106, data_r, 32'd0);
    addr_r = 5'd15;
    #1 chk("arst_ehbr", 106, data_r, 32'h8);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 12, 0, 0, 0, 0, 32'h0, 0, 32'h0), 107);
    apply(mk(0, 0, 13, 0, 0, 0, 0, 32'h0, 0, 32'h0), 108);
    apply(mk(1, 0, 15, 0, 0, 0, 0, 32'h8, 0, 32'h0), 109);
    apply(mk(1, 1, 12, 12, 32'h3, 0, 0, 32'h3, 0, 32'h0), 110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 clk  in  1  main clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset; asynchronous, active-low.
REQ-003 en  in  1  stage enable from pipeline control; when 0, no architectural state changes and no new events.
REQ-004 oper  in  2  coprocessor operation: EXE_CP_NONE=0, EXE_CP_STORE=1 (MTC0), EXE_CP0_ERET=2; value 3 is treated as NONE.
REQ-005 addr_r  in  5  CP0 register number for MFC0 read.
REQ-006 data_r  out  32  MFC0 read data.
REQ-007 addr_w  in  5  CP0 register number for MTC0.
REQ-008 data_w  in  32  MTC0 write data.
REQ-009 ret_addr  in  32  address of the instruction currently in ID; captured into EPC on interrupt entry.
REQ-010 irq  in  1  external interrupt request; asynchronous level.
REQ-011 jump_en  out  1  registered one-cycle redirect pulse to the pipeline controller.
REQ-012 jump_addr  out  32  registered redirect target; valid while jump_en=1.

Function
REQ-013 CP0 registers: STATUS (12; bit0 IE, bit1 EXL, other bits read 0), CAUSE (13; bit10 IP2 = pending, read-only; other bits read 0), EPC (14), EHBR (15; handler base).
REQ-014 data_r is combinational from addr_r and returns pre-write values during a same-cycle MTC0.
REQ-015 data_r reads 0 for any unimplemented register number.
REQ-016 irq passes through a 2-flop synchronizer; a rising edge of the synchronized signal sets pending.
REQ-017 Latency: with irq first high at edge N, pending is set at edge N+2.
REQ-018 FSM states: IDLE, ENTER, ISR, EXIT.
REQ-019 IDLE -> ENTER at the edge where en=1, pending=1, IE=1, EXL=0.
REQ-020 On the IDLE -> ENTER transition: EPC<=ret_addr, EXL<=1, pending<=0, jump_addr<=EHBR.
REQ-021 ENTER: jump_en=1 for exactly one cycle, then the FSM moves to ISR.
REQ-022 ISR -> EXIT when en=1 and oper=ERET; on that transition EXL<=0 and jump_addr<=EPC.
REQ-023 EXIT: jump_en=1 for one cycle, then the FSM moves to IDLE.
REQ-024 ERET in IDLE behaves identically: the FSM goes to EXIT.
REQ-025 MTC0 commits when en=1 in IDLE or ISR.
REQ-026 MTC0 writes to CAUSE or to unimplemented registers are ignored.
REQ-027 Interrupt entry has priority over a same-cycle MTC0 or ERET in IDLE; that oper is dropped, and because ret_addr is captured, the instruction re-executes after return.
REQ-028 In ENTER and EXIT, oper is ignored and no new interrupt is recognized.
REQ-029 A new irq edge during ISR sets pending; the interrupt is taken only after EXIT, back in IDLE.
REQ-030 Pending holds across en=0 cycles.
REQ-031 jump_en=0 in IDLE and ISR.
REQ-032 jump_addr holds its last value outside ENTER and EXIT.

Reset
REQ-033 On rst_n=0, asynchronously: FSM=IDLE, STATUS=0 (IE=0, EXL=0), pending=0, EPC=0, EHBR=32'h0000_0008, synchronizer flops=0, jump_en=0, jump_addr=0.
REQ-034 Reset asserted mid-ENTER or mid-EXIT aborts the redirect; no jump_en pulse follows deassertion.
REQ-035 The first rising edge after deassertion performs normal operation.

Structure
REQ-036 oper encodings, CP0 register numbers, STATUS/CAUSE bit positions, the EHBR reset value and FSM state encodings live in the shared define header alongside the existing pipeline constants.
REQ-037 One sub-module, irq_sync, contains the 2-flop synchronizer and rising-edge detector; everything else is in cp0_unit.

Verification
REQ-038 Reset, then MTC0 STATUS=1 and MFC0 STATUS -> data_r=1; MTC0 CAUSE=0xFFFFFFFF -> CAUSE still reads 0.
REQ-039 IE=1, ret_addr=0x40, irq high at edge N -> jump_en=1 in the cycle after edge N+3, jump_addr=0x8, EPC=0x40, EXL=1.
REQ-040 In ISR, ERET with en=1 -> one-cycle jump_en, jump_addr=0x40, EXL=0, FSM back in IDLE.
REQ-041 Second irq edge during ISR -> CAUSE bit10=1 while in ISR; second entry occurs the cycle after EXIT.
REQ-042 Interrupt pending with MTC0 EHBR=0x100 in the same cycle -> entry wins, jump_addr=0x8, EHBR unchanged; en=0 with pending=1 -> no entry until en=1.
REQ-043 rst_n pulsed low during ENTER -> jump_en=0 immediately, all registers at reset values, no later pulse.
